// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the instruction/data memory bus arbiter.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_e;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } port_e;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon master between a fetch port and a
// data port, with a per-transfer waitrequest timeout and a sticky error flag.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   // instruction fetch port
   input  logic        i_read,
   input  logic [31:0] i_address,
   output logic [31:0] i_readdata,
   output logic        i_waitrequest,
   // data port
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_address,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic [31:0] d_readdata,
   output logic        d_waitrequest,
   // Avalon master toward RAM
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   // sticky timeout flag
   output logic        err
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e           state;
   port_e            last_grant;
   logic [CNT_W-1:0] wait_cnt;

   logic d_req_c;
   logic grant_req_c;

   // Request of whichever port currently owns the bus.
   always_comb begin
      d_req_c     = d_read | d_write;
      grant_req_c = 1'b0;
      case (state)
         GRANT_I: grant_req_c = i_read;
         GRANT_D: grant_req_c = d_req_c;
         default: grant_req_c = 1'b0;
      endcase
   end

   // Arbitration, transfer tracking, wait counter and sticky error.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= PORT_I;
         wait_cnt   <= '0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               wait_cnt <= '0;
               // on a tie the port that did not win last time is served
               if (i_read && (!d_req_c || last_grant == PORT_D)) begin
                  state      <= GRANT_I;
                  last_grant <= PORT_I;
               end else if (d_req_c) begin
                  state      <= GRANT_D;
                  last_grant <= PORT_D;
               end
            end
            GRANT_I, GRANT_D: begin
               if (!grant_req_c || !waitrequest) begin
                  // completion, or requester withdrew mid-transfer
                  state <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
                  if (wait_cnt == CNT_LAST) begin
                     state <= IDLE;
                     err   <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Master and port signals follow the granted port; everyone else stalls.
   always_comb begin
      address       = '0;
      read          = 1'b0;
      write         = 1'b0;
      writedata     = '0;
      byteenable    = '0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      i_readdata    = '0;
      d_readdata    = '0;
      case (state)
         GRANT_I: begin
            address       = i_address;
            read          = i_read;
            byteenable    = 4'hF;
            i_waitrequest = waitrequest;
            i_readdata    = readdata;
         end
         GRANT_D: begin
            address       = d_address;
            write         = d_write;
            read          = d_read & ~d_write;
            writedata     = d_writedata;
            byteenable    = d_byteenable;
            d_waitrequest = waitrequest;
            d_readdata    = readdata;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum m_waitrequest-high cycles per granted transfer before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_read  input  1  instruction-fetch read request.
REQ-005 SHALL have port i_address  input  32  fetch byte address.
REQ-006 SHALL have port i_readdata  output  32  fetch read data.
REQ-007 SHALL have port i_waitrequest  output  1  fetch stall.
REQ-008 SHALL have ports d_read and d_write  input  1 each  data-port read and write requests.
REQ-009 SHALL have ports d_address and d_writedata  input  32 each  data-port address and write data.
REQ-010 SHALL have port d_byteenable  input  4  data-port byte lanes.
REQ-011 SHALL have ports d_readdata (output, 32) and d_waitrequest (output, 1): data read data and data stall.
REQ-012 SHALL have ports address (output, 32), read (output, 1), write (output, 1), writedata (output, 32), byteenable (output, 4), forming the Avalon master toward RAM.
REQ-013 SHALL have ports waitrequest (input, 1) and readdata (input, 32) from RAM.
REQ-014 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT_I, GRANT_D.
REQ-016 In IDLE: read=write=0, address=0, writedata=0, byteenable=0; arbitration decided combinationally and registered, so a grant state is entered on the next edge (1-cycle arbitration latency).
REQ-017 IDLE with only fetch request -> GRANT_I; only data request (d_read|d_write) -> GRANT_D; both -> port NOT in last_grant register (round-robin).
REQ-018 last_grant SHALL update on entering a grant state; reset value = I, so data wins the first tie.
REQ-019 In GRANT_x: master outputs SHALL follow port x combinationally. For I: byteenable=4'hF, write=0.
REQ-020 d_read and d_write both high SHALL be treated as write; read=0.
REQ-021 Granted port waitrequest SHALL equal master waitrequest. Every other port waitrequest SHALL be 1.
REQ-022 Granted port readdata SHALL equal master readdata; non-granted port readdata SHALL be 0.
REQ-023 A transfer completes on an edge where the grant state holds, request is high and waitrequest=0; FSM then returns to IDLE. Minimum 2 cycles per transfer; back-to-back alternating grants under continuous contention.
REQ-024 Request deasserted while granted (protocol violation) SHALL return FSM to IDLE next edge, with no err.
REQ-025 A wait counter SHALL clear on grant entry and increment each granted cycle with waitrequest=1.
REQ-026 Reaching TIMEOUT SHALL: return FSM to IDLE, set err, and hold the requester's waitrequest high through that cycle.
REQ-027 err SHALL remain set until reset.

Reset
REQ-028 reset SHALL asynchronously force IDLE, last_grant=I, wait counter=0, err=0, with all master outputs 0, i/d_waitrequest=1 and i/d_readdata=0.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer; no completion is signalled to either port.

Structure
REQ-030 Package mem_bus_pkg SHALL hold the state enum (IDLE, GRANT_I, GRANT_D), the port-id enum (PORT_I, PORT_D) and the TIMEOUT default constant.
REQ-031 A single module with no sub-module SHALL be used; FSM, round-robin bit and wait counter are inline.

Verification
REQ-032 Fetch only: i_read=1, i_address=32'h4, RAM waitrequest low -> read=1, address=32'h4 in cycle 2; i_readdata=32'h24030020, i_waitrequest=0 that cycle; IDLE next.
REQ-033 Simultaneous i_read and d_write after reset -> GRANT_D first, then GRANT_I on the next arbitration. i_waitrequest=1 throughout the data transfer.
REQ-034 Continuous contention for 8 transfers -> grants strictly alternate D,I,D,I,... with no port starved.
REQ-035 d_write=1, d_byteenable=4'h3, waitrequest held high 3 cycles -> master signals stable for 4 granted cycles, then completion, with err=0.
REQ-036 TIMEOUT=4 with waitrequest stuck high -> FSM returns to IDLE after 4 waited cycles; err=1 and stays 1 until reset pulse.
REQ-037 reset asserted during GRANT_D wait -> outputs reach reset values immediately, without waiting for a clock edge; the first post-reset tie grants D.
